rs422_uart_rx: RTL
==================

// Module: rs422_uart_rx
// PURPOSE
//  Byte-level receiving end of our differential serial link. Slices the 3-bit
//  rda/rdb pair levels into a line bit and recovers 8N1 async frames
//  (start, DATA_BITS LSB-first, stop) by mid-bit sampling.
//  Presents each byte on a valid/ready port to the downstream consumer.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; even, >= 4
//  DATA_BITS     8   data bits per frame
//  LEVEL_W       3   width of each differential level input
// PORTS
//  clk         in   1          single clock, all logic on posedge
//  rst_n       in   1          reset, asynchronous assert, active-low
//  rda         in   LEVEL_W    differential leg A level
//  rdb         in   LEVEL_W    differential leg B level
//  rx_data     out  DATA_BITS  received byte, stable while rx_valid=1
//  rx_valid    out  1          byte available
//  rx_ready    in   1          consumer accepts when rx_valid && rx_ready
//  frame_err   out  1          1-cycle pulse: stop bit sampled 0
//  overrun     out  1          1-cycle pulse: byte dropped, buffer full
// BEHAVIOUR
//  Reset: state=IDLE; rx_data=0, rx_valid=0, frame_err=0, overrun=0; line bit=1.
//  Slicer: unsigned compare. rda<rdb -> 1 (mark). rda>rdb -> 0 (space).
//   rda==rdb -> hold previous bit. Result goes through a 2-flop synchronizer.
//   All timing below uses the synchronized bit s.
//  Baud counter cnt: 0..CLKS_PER_BIT-1. bit_idx: 0..DATA_BITS-1.
//  IDLE: s==0 -> START, cnt=0.
//  START: at cnt==CLKS_PER_BIT/2-1, sample s.
//   s==1 -> glitch, IDLE, no flags. s==0 -> DATA, cnt=0, bit_idx=0.
//  DATA: at cnt==CLKS_PER_BIT-1 (mid-bit), shift s into bit bit_idx, LSB first.
//   After bit DATA_BITS-1 -> STOP, cnt=0.
//  STOP: at cnt==CLKS_PER_BIT-1, sample s.
//   s==1 -> deliver byte, IDLE.
//   s==0 -> frame_err pulse next cycle, byte discarded, WAIT_MARK.
//  WAIT_MARK: stay until s==1, then IDLE. Treats a held-space break as one error.
//  Deliver: rx_valid/rx_data update the cycle after the stop sample (latency 1).
//   Buffer empty, or rx_ready=1 that same cycle -> load byte, rx_valid=1.
//   Buffer full and rx_ready=0 -> keep old byte, pulse overrun.
//  Handshake: rx_valid drops the cycle after rx_valid&&rx_ready unless a new
//   byte loads in that same cycle, in which case it stays 1.
//   rx_data never changes while rx_valid=1 && !rx_ready.
//  Reset mid-frame: frame abandoned immediately, all outputs to reset values.
// STRUCTURE
//  rs422_pkg:
//   state enum {IDLE, START, DATA, STOP, WAIT_MARK}
//   MARK_A=1, MARK_B=6, SPACE_A=6, SPACE_B=1 level constants (shared with TX)
//  Sub-module rs422_diff_slicer: compare + hold-on-equal + 2-flop sync, out s.
//  Top: FSM, baud/bit counters, shift register, output buffer.
// TESTING  (CLKS_PER_BIT=16, rx_ready=1 unless stated)
//  1 Frame 0xA5 at MARK/SPACE levels -> rx_data=0xA5, one-cycle rx_valid,
//    rises 1 clk after stop sample, no flags.
//  2 Space held 5 clks, then mark -> no rx_valid, no frame_err, FSM back in IDLE.
//  3 Frame 0x3C with stop bit=space for 20 bits -> one frame_err pulse,
//    no rx_valid; next 0x81 frame received correctly.
//  4 rx_ready=0, frames 0x11 then 0x22 -> rx_data=0x11 held, one overrun pulse.
//    Then rx_ready=1 -> 0x11 accepted, rx_valid=0.
//  5 rda=rdb=3 for 4 clks mid-bit of a 1 bit in frame 0xFF -> byte 0xFF, no flags.
//  6 rst_n low at data bit 4 of 0x5A, release, send 0xC3 -> only 0xC3 delivered.

Source files
------------

// File: rtl/rs422_pkg.sv
// Shared definitions for the RS-422 serial link: receiver FSM states and
// the differential level pair each leg drives for mark and space.
package rs422_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_MARK
    } rx_state_t;

    localparam logic [2:0] MARK_A  = 3'd1;
    localparam logic [2:0] MARK_B  = 3'd6;
    localparam logic [2:0] SPACE_A = 3'd6;
    localparam logic [2:0] SPACE_B = 3'd1;

endpackage

// File: rtl/rs422_diff_slicer.sv
// Turns the rda/rdb level pair into a line bit (hold on equal levels) and
// brings it into the clk domain through a 2-flop synchronizer.
module rs422_diff_slicer #(
    parameter int LEVEL_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LEVEL_W-1:0] rda,
    input  logic [LEVEL_W-1:0] rdb,
    output logic               s
);

    logic line_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
        end else begin
            // Equal levels carry no information, so the last decision is kept
            if (rda < rdb)
                line_p0 <= 1'b1;
            else if (rda > rdb)
                line_p0 <= 1'b0;
            sync_p1 <= line_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign s = sync_p2;

endmodule

// File: rtl/rs422_uart_rx.sv
// 8N1 asynchronous receiver for the RS-422 link: mid-bit sampling FSM and a
// one-deep valid/ready output buffer with frame-error and overrun pulses.
module rs422_uart_rx
    import rs422_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int LEVEL_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LEVEL_W-1:0]   rda,
    input  logic [LEVEL_W-1:0]   rdb,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 s;
    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 deliver;
    logic                 ferr_d;

    rs422_diff_slicer #(
        .LEVEL_W (LEVEL_W)
    ) u_slicer (
        .clk   (clk),
        .rst_n (rst_n),
        .rda   (rda),
        .rdb   (rdb),
        .s     (s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!s)
                    state_d = START;
            end
            START: begin
                // Half a bit in: confirms the start edge and sets the mid-bit phase
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = s;
                    if (idx_q == IDX_LAST)
                        state_d = STOP;
                    else
                        idx_d = idx_q + IDX_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_MARK;
                    end
                end
            end
            WAIT_MARK: begin
                cnt_d = '0;
                if (s)
                    state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            overrun   <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg_q;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
